// File: rtl/stereo_smpl_queue_pkg.sv
// Shared types and defaults for the equalizer sample queue.
package eq_queue_pkg;
  localparam int DEPTH_DEF    = 1024;
  localparam int NUM_TAPS_DEF = 1021;

  typedef enum logic [1:0] {FILL, IDLE, READ} q_state_t;
  typedef logic signed [15:0] smpl_t;
endpackage

// File: rtl/stereo_smpl_queue_if.sv
// Sample-in / window-out bus of stereo_smpl_queue.
// QUEUE_OVERRUN_FLAG_EN adds the overrun pulse to the bus.
interface stereo_smpl_queue_if;
  import eq_queue_pkg::*;

  logic  wrt_smpl;
  smpl_t lft_in;
  smpl_t rght_in;
  logic  sequencing;
  smpl_t lft_out;
  smpl_t rght_out;
`ifdef QUEUE_OVERRUN_FLAG_EN
  logic  overrun;

  modport master (output wrt_smpl, lft_in, rght_in,
                  input  sequencing, lft_out, rght_out, overrun);
  modport slave  (input  wrt_smpl, lft_in, rght_in,
                  output sequencing, lft_out, rght_out, overrun);
`else
  modport master (output wrt_smpl, lft_in, rght_in,
                  input  sequencing, lft_out, rght_out);
  modport slave  (input  wrt_smpl, lft_in, rght_in,
                  output sequencing, lft_out, rght_out);
`endif
endinterface

// File: rtl/stereo_smpl_queue_mem.sv
// DEPTH x 32 sample store: one write port, one registered read port.
// The read register clears when no read is issued so idle outputs read 0.
module dualport_mem16 #(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_d, rd_data_q;

  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;

  always_comb rd_data_d = re ? mem[rd_addr] : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;

  assign rd_data = rd_data_q;
endmodule

// File: rtl/stereo_smpl_queue.sv
// Circular stereo sample queue: after each write with a full window, streams the last NUM_TAPS samples oldest first.
// QUEUE_OVERRUN_FLAG_EN adds an overrun pulse when a pending readout is overwritten.
module stereo_smpl_queue
  import eq_queue_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_TAPS = NUM_TAPS_DEF
) (
  input logic               clk,
  input logic               rst_n,
  stereo_smpl_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_TAPS + 1);
  localparam logic [PW-1:0] P1   = PW'(1);
  localparam logic [CW-1:0] C1   = CW'(1);
  localparam logic [CW-1:0] TAPS = CW'(NUM_TAPS);
  localparam logic [CW-1:0] LAST = CW'(NUM_TAPS - 1);

  q_state_t      state_d, state_q;
  logic [PW-1:0] new_ptr_d, new_ptr_q, old_ptr_d, old_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] cnt_d, cnt_q, rd_cnt_d, rd_cnt_q;
  logic          pending_d, pending_q, gap_d, gap_q, seq_d, seq_q;
  logic          overrun_d, overrun_q;
  logic          wr, rd_en;
  logic [31:0]   rd_data;

  assign wr    = bus.wrt_smpl;
  assign rd_en = (state_q == READ) && !gap_q;

  always_comb begin
    state_d   = state_q;
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rd_cnt_d  = rd_cnt_q;
    pending_d = pending_q;
    gap_d     = gap_q;
    seq_d     = rd_en;
    overrun_d = wr && pending_q;

    if (wr) begin
      new_ptr_d = new_ptr_q + P1;
      if (cnt_q == TAPS) old_ptr_d = old_ptr_q + P1;
      else               cnt_d     = cnt_q + C1;
    end

    case (state_q)
      FILL, IDLE: if (wr && cnt_d == TAPS) begin
        state_d  = READ;
        rd_ptr_d = old_ptr_d;
        rd_cnt_d = '0;
      end
      READ: begin
        // gap_q holds one idle cycle between back-to-back windows so the filter sees a rising edge
        if (gap_q) begin
          gap_d     = 1'b0;
          pending_d = pending_q | wr;
        end else if (rd_cnt_q == LAST) begin
          rd_cnt_d  = '0;
          pending_d = 1'b0;
          if (pending_q || wr) begin
            gap_d    = 1'b1;
            rd_ptr_d = old_ptr_d;
          end else begin
            state_d = IDLE;
          end
        end else begin
          rd_ptr_d  = rd_ptr_q + P1;
          rd_cnt_d  = rd_cnt_q + C1;
          pending_d = pending_q | wr;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= FILL;
      new_ptr_q <= '0;
      old_ptr_q <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_cnt_q  <= '0;
      pending_q <= 1'b0;
      gap_q     <= 1'b0;
      seq_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_ptr_q <= new_ptr_d;
      old_ptr_q <= old_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      pending_q <= pending_d;
      gap_q     <= gap_d;
      seq_q     <= seq_d;
      overrun_q <= overrun_d;
    end

  dualport_mem16 #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr),
    .wr_addr (new_ptr_q),
    .wr_data ({bus.lft_in, bus.rght_in}),
    .re      (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign bus.sequencing = seq_q;
  assign bus.lft_out    = smpl_t'(rd_data[31:16]);
  assign bus.rght_out   = smpl_t'(rd_data[15:0]);
`ifdef QUEUE_OVERRUN_FLAG_EN
  assign bus.overrun    = overrun_q;
`endif
endmodule

// File: tb/tb_stereo_smpl_queue.sv
// Directed bench for stereo_smpl_queue: fill, bursts, pointer wrap, pending window, mid-burst reset.
module tb_stereo_smpl_queue;
  import eq_queue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stereo_smpl_queue_if bus();
  stereo_smpl_queue #(.DEPTH(1024), .NUM_TAPS(1021)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {int first; int len; int start; int bad;} burst_t;
  typedef struct {string name; int first; int len;} exp_t;

  burst_t bq[$];
  burst_t cur;
  bit     in_b;
  int     nxt, zero_viol, ov_cnt, cyc, nvec, nerr;

  always @(posedge clk) cyc <= cyc + 1;

  // Burst recorder: every window must be lft=k, rght=-k with k consecutive.
  always @(negedge clk) begin
    if (bus.sequencing === 1'b1) begin
      if (!in_b) begin
        in_b = 1'b1;
        cur = '{first: int'(bus.lft_out), len: 0, start: cyc, bad: 0};
        nxt = cur.first;
      end
      if (int'(bus.lft_out) != nxt || int'(bus.rght_out) != -nxt) cur.bad = cur.bad + 1;
      nxt = nxt + 1;
      cur.len = cur.len + 1;
    end else begin
      if (in_b) begin
        bq.push_back(cur);
        in_b = 1'b0;
      end
      if (bus.lft_out !== 16'sd0 || bus.rght_out !== 16'sd0) zero_viol = zero_viol + 1;
    end
`ifdef QUEUE_OVERRUN_FLAG_EN
    if (bus.overrun === 1'b1) ov_cnt = ov_cnt + 1;
`endif
  end

  task automatic chk(string nm, logic signed [31:0] act, logic signed [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(int k, output int t);
    @(negedge clk);
    t = cyc;
    bus.wrt_smpl = 1'b1;
    bus.lft_in   = smpl_t'(k);
    bus.rght_in  = smpl_t'(-k);
    @(negedge clk);
    bus.wrt_smpl = 1'b0;
  endtask

  task automatic wait_nb(int n, string nm);
    int b = 0;
    while (bq.size() < n && b < 5000) begin
      @(negedge clk); #1; b++;
    end
    if (bq.size() < n) chk({nm, "_timeout"}, bq.size(), n);
  endtask

  task automatic wait_len(int l, string nm);
    int b = 0;
    while (!(in_b && cur.len >= l) && b < 5000) begin
      @(negedge clk); #1; b++;
    end
    if (!(in_b && cur.len >= l)) chk({nm, "_timeout"}, cur.len, l);
  endtask

  function automatic int st(int i);
    return (i < bq.size()) ? bq[i].start : -99999;
  endfunction

  initial begin
    exp_t ev[6];
    int t, t0, t1, t2, t5;
    ev[0] = '{"first",    1,    1021};
    ev[1] = '{"idle_wr",  2,    1021};
    ev[2] = '{"wrap_a",   3,    1021};
    ev[3] = '{"wrap_b",   10,   1021};
    ev[4] = '{"mid_rst",  12,   300};
    ev[5] = '{"post_rst", 2001, 1021};

    bus.wrt_smpl = 1'b0;
    bus.lft_in   = '0;
    bus.rght_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_seq",  bus.sequencing, 0);
    chk("rst_lft",  bus.lft_out, 0);
    chk("rst_rght", bus.rght_out, 0);
    rst_n = 1'b1;

    for (int k = 1; k <= 1020; k++) wr(k, t);
    repeat (30) @(negedge clk);
    chk("fill_no_burst", bq.size() + int'(in_b), 0);

    wr(1021, t0);
    wait_nb(1, "first");
    wr(1022, t1);
    wait_nb(2, "idle_wr");

    // 1023 starts a window; 1024..1030 arrive mid-readout and collapse into one pending window
    wr(1023, t2);
    for (int k = 1024; k <= 1030; k++) wr(k, t);
    wait_nb(3, "wrap_a");
    wait_len(500, "wrap_b500");
    ov_cnt = 0;
    wr(1031, t);
    wait_len(700, "wrap_b700");
    wr(1032, t);
    repeat (3) @(negedge clk);
`ifdef QUEUE_OVERRUN_FLAG_EN
    chk("overrun_pulses", ov_cnt, 1);
`endif

    wait_nb(4, "wrap_b");
    wait_len(300, "mid300");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_seq",  bus.sequencing, 0);
    chk("mid_rst_lft",  bus.lft_out, 0);
    chk("mid_rst_rght", bus.rght_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 2001; k <= 3020; k++) wr(k, t);
    repeat (30) @(negedge clk);
    chk("refill_no_burst", bq.size() * 2 + int'(in_b), 10);
    wr(3021, t5);
    wait_nb(6, "post_rst");
    repeat (5) @(negedge clk);

    chk("n_bursts", bq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < bq.size()) begin
        chk({ev[i].name, "_first"}, bq[i].first, ev[i].first);
        chk({ev[i].name, "_len"},   bq[i].len,   ev[i].len);
        chk({ev[i].name, "_order"}, bq[i].bad,   0);
      end else begin
        chk({ev[i].name, "_missing"}, i, bq.size());
      end
    end
    chk("lat_first", st(0) - t0, 2);
    chk("lat_idle",  st(1) - t1, 2);
    chk("lat_wrap",  st(2) - t2, 2);
    chk("lat_post",  st(5) - t5, 2);
    chk("gap_ab",    st(3) - st(2), 1022);
    chk("gap_bc",    st(4) - st(3), 1022);
    chk("idle_zero", zero_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
